// File: rtl/lpc_io_target_if.sv
// LPC pin and peripheral-side signal bundle for lpc_io_target.
// master: host / peripheral model side; slave: the LPC I/O target.
interface lpc_io_target_if;
   logic        lframe_n;
   logic [3:0]  lad_in;
   logic [3:0]  lad_out;
   logic        lad_oe;
   logic [15:0] addr;
   logic [7:0]  din;
   logic [7:0]  dout;
   logic        io_rden;
   logic        io_wren;
   logic        device_cs;
   logic        lpc_en;

   modport master (
      output lframe_n, lad_in, dout,
      input  lad_out, lad_oe, addr, din, io_rden, io_wren, device_cs, lpc_en
   );

   modport slave (
      input  lframe_n, lad_in, dout,
      output lad_out, lad_oe, addr, din, io_rden, io_wren, device_cs, lpc_en
   );
endinterface

// File: rtl/lpc_io_target.sv
// LPC I/O-cycle target: claims I/O read/write cycles in an 8-byte window at
// BASE_ADDR and converts them into single-byte peripheral strobes.
// Optional LPC_LWAIT_EN: inserts SYNC_WAIT long-wait SYNC nibbles (0110)
// ahead of the ready SYNC (0000).
module lpc_io_target #(
   parameter logic [15:0] BASE_ADDR = 16'h03F8,
   parameter int unsigned SYNC_WAIT = 2
) (
   input  logic           lclk,
   input  logic           lreset_n,
   lpc_io_target_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_CYCTYPE, S_ADDR, S_WDATA, S_HTAR, S_SYNC, S_RDATA, S_PTAR
   } state_t;

   state_t      state, state_nx;
   logic [7:0]  cnt, cnt_nx;
   logic        is_wr, is_wr_nx;
   logic [11:0] addr_sr, addr_sr_nx;
   logic [7:0]  rdata, rdata_nx;
   logic [15:0] full_addr, offset;
   logic        sync_done;

   logic [3:0]  lad_out, lad_out_nx;
   logic        lad_oe, lad_oe_nx;
   logic [15:0] addr, addr_nx;
   logic [7:0]  din, din_nx;
   logic        io_rden, io_rden_nx;
   logic        io_wren, io_wren_nx;
   logic        device_cs, device_cs_nx;
   logic        lpc_en, lpc_en_nx;

`ifndef LPC_LWAIT_EN
   logic unused_sync_wait;
   assign unused_sync_wait = ^SYNC_WAIT;
`endif

   // Address as it will stand once the current nibble is shifted in.
   assign full_addr = {addr_sr, bus.lad_in};
   assign offset    = full_addr - BASE_ADDR;

   assign bus.lad_out   = lad_out;
   assign bus.lad_oe    = lad_oe;
   assign bus.addr      = addr;
   assign bus.din       = din;
   assign bus.io_rden   = io_rden;
   assign bus.io_wren   = io_wren;
   assign bus.device_cs = device_cs;
   assign bus.lpc_en    = lpc_en;

   // State and registered outputs.
   always_ff @(posedge lclk or negedge lreset_n) begin
      if (!lreset_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         is_wr     <= 1'b0;
         addr_sr   <= '0;
         rdata     <= '0;
         lad_out   <= '1;
         lad_oe    <= 1'b0;
         addr      <= '0;
         din       <= '0;
         io_rden   <= 1'b0;
         io_wren   <= 1'b0;
         device_cs <= 1'b0;
         lpc_en    <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         is_wr     <= is_wr_nx;
         addr_sr   <= addr_sr_nx;
         rdata     <= rdata_nx;
         lad_out   <= lad_out_nx;
         lad_oe    <= lad_oe_nx;
         addr      <= addr_nx;
         din       <= din_nx;
         io_rden   <= io_rden_nx;
         io_wren   <= io_wren_nx;
         device_cs <= device_cs_nx;
         lpc_en    <= lpc_en_nx;
      end
   end

   // Next state plus next output values; outputs are computed one cycle
   // ahead so every pin-facing signal comes straight from a flop.
   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      is_wr_nx     = is_wr;
      addr_sr_nx   = addr_sr;
      rdata_nx     = rdata;
      lad_out_nx   = lad_out;
      lad_oe_nx    = lad_oe;
      addr_nx      = addr;
      din_nx       = din;
      io_rden_nx   = 1'b0;
      io_wren_nx   = 1'b0;
      device_cs_nx = device_cs;
      lpc_en_nx    = lpc_en;
      sync_done    = 1'b0;

      if (!bus.lframe_n) begin
         // START (or abort of a cycle in progress): release the bus, drop
         // the claim and look for a fresh start code.
         state_nx     = (bus.lad_in == 4'b0000) ? S_CYCTYPE : S_IDLE;
         cnt_nx       = '0;
         lad_oe_nx    = 1'b0;
         lad_out_nx   = '1;
         device_cs_nx = 1'b0;
         lpc_en_nx    = 1'b0;
      end else begin
         unique case (state)
            S_IDLE: ;
            S_CYCTYPE: begin
               cnt_nx = '0;
               if (bus.lad_in[3:1] == 3'b000) begin
                  is_wr_nx = 1'b0;
                  state_nx = S_ADDR;
               end else if (bus.lad_in[3:1] == 3'b001) begin
                  is_wr_nx = 1'b1;
                  state_nx = S_ADDR;
               end else begin
                  state_nx = S_IDLE;
               end
            end
            S_ADDR: begin
               addr_sr_nx = {addr_sr[7:0], bus.lad_in};
               if (cnt == 8'd3) begin
                  cnt_nx = '0;
                  if (offset[15:3] == '0) begin
                     device_cs_nx = 1'b1;
                     lpc_en_nx    = 1'b1;
                     addr_nx      = {13'b0, offset[2:0]};
                     state_nx     = is_wr ? S_WDATA : S_HTAR;
                  end else begin
                     state_nx = S_IDLE;
                  end
               end else begin
                  cnt_nx = cnt + 8'd1;
               end
            end
            S_WDATA: begin
               if (cnt == 8'd0) begin
                  din_nx[3:0] = bus.lad_in;
                  cnt_nx      = 8'd1;
               end else begin
                  din_nx[7:4] = bus.lad_in;
                  cnt_nx      = '0;
                  state_nx    = S_HTAR;
               end
            end
            S_HTAR: begin
               if (cnt == 8'd0) begin
                  cnt_nx     = 8'd1;
                  io_rden_nx = !is_wr;
               end else begin
                  cnt_nx    = '0;
                  state_nx  = S_SYNC;
                  lad_oe_nx = 1'b1;
`ifdef LPC_LWAIT_EN
                  if (SYNC_WAIT != 0) begin
                     lad_out_nx = 4'b0110;
                  end else begin
                     lad_out_nx = 4'b0000;
                     io_wren_nx = is_wr;
                  end
`else
                  lad_out_nx = 4'b0000;
                  io_wren_nx = is_wr;
`endif
               end
            end
            S_SYNC: begin
`ifdef LPC_LWAIT_EN
               // cnt counts long-wait nibbles already on the bus; the ready
               // SYNC (and the write strobe) follows the last of them.
               if (32'(cnt) < SYNC_WAIT) begin
                  cnt_nx = cnt + 8'd1;
                  if (32'(cnt) + 32'd1 < SYNC_WAIT) begin
                     lad_out_nx = 4'b0110;
                  end else begin
                     lad_out_nx = 4'b0000;
                     io_wren_nx = is_wr;
                  end
               end else begin
                  sync_done = 1'b1;
               end
`else
               sync_done = 1'b1;
`endif
               if (sync_done) begin
                  cnt_nx = '0;
                  if (is_wr) begin
                     state_nx   = S_PTAR;
                     lad_out_nx = 4'b1111;
                  end else begin
                     state_nx   = S_RDATA;
                     rdata_nx   = bus.dout;
                     lad_out_nx = bus.dout[3:0];
                  end
               end
            end
            S_RDATA: begin
               if (cnt == 8'd0) begin
                  cnt_nx     = 8'd1;
                  lad_out_nx = rdata[7:4];
               end else begin
                  cnt_nx     = '0;
                  state_nx   = S_PTAR;
                  lad_out_nx = 4'b1111;
               end
            end
            S_PTAR: begin
               if (cnt == 8'd0) begin
                  cnt_nx    = 8'd1;
                  lad_oe_nx = 1'b0;
               end else begin
                  cnt_nx       = '0;
                  state_nx     = S_IDLE;
                  device_cs_nx = 1'b0;
                  lpc_en_nx    = 1'b0;
               end
            end
            default: state_nx = S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lpc_io_target.sv
// Directed bench for lpc_io_target: per-cycle trace of outputs, checked
// against hand-derived cycle tables (shifted by 2 with LPC_LWAIT_EN).
module tb_lpc_io_target;
`ifdef LPC_LWAIT_EN
   localparam int W = 2;
`else
   localparam int W = 0;
`endif

   logic lclk = 1'b0;
   logic lreset_n = 1'b0;

   lpc_io_target_if bus();

   lpc_io_target #(.BASE_ADDR(16'h03F8), .SYNC_WAIT(2)) dut (
      .lclk(lclk),
      .lreset_n(lreset_n),
      .bus(bus)
   );

   always #15 lclk = ~lclk;

   int passed = 0;
   int total = 0;
   int idx = 0;

   logic        t_oe[64];
   logic [3:0]  t_out[64];
   logic        t_rden[64];
   logic        t_wren[64];
   logic        t_cs[64];
   logic        t_en[64];
   logic [15:0] t_addr[64];
   logic [7:0]  t_din[64];
   logic [7:0]  rd_val = 8'h00;
   logic        pend = 1'b0;

   // One LPC clock: drive host inputs, sample outputs mid-cycle, and let the
   // peripheral model present rd_val the cycle after it sees io_rden.
   task automatic cyc(input logic fr, input logic [3:0] nib);
      bus.lframe_n = fr;
      bus.lad_in   = nib;
      @(negedge lclk);
      if (idx < 64) begin
         t_oe[idx]   = bus.lad_oe;
         t_out[idx]  = bus.lad_out;
         t_rden[idx] = bus.io_rden;
         t_wren[idx] = bus.io_wren;
         t_cs[idx]   = bus.device_cs;
         t_en[idx]   = bus.lpc_en;
         t_addr[idx] = bus.addr;
         t_din[idx]  = bus.din;
      end
      pend = bus.io_rden;
      idx++;
      @(posedge lclk);
      #1;
      if (pend) bus.dout = rd_val;
   endtask

   task automatic send_hdr(input logic [3:0] ct, input logic [15:0] a);
      cyc(1'b0, 4'h0);
      cyc(1'b1, ct);
      cyc(1'b1, a[15:12]);
      cyc(1'b1, a[11:8]);
      cyc(1'b1, a[7:4]);
      cyc(1'b1, a[3:0]);
   endtask

   task automatic test_reset;
      bus.lframe_n = 1'b1;
      bus.lad_in   = 4'hF;
      bus.dout     = 8'h00;
      lreset_n     = 1'b0;
      repeat (3) @(posedge lclk);
      @(negedge lclk);
      total++; if (bus.lad_out !== 4'hF) $display("FAIL rst_lad_out got %h want f", bus.lad_out); else passed++;
      total++; if (bus.lad_oe !== 1'b0) $display("FAIL rst_lad_oe got %b want 0", bus.lad_oe); else passed++;
      total++; if (bus.addr !== 16'h0) $display("FAIL rst_addr got %h want 0000", bus.addr); else passed++;
      total++; if (bus.din !== 8'h0) $display("FAIL rst_din got %h want 00", bus.din); else passed++;
      total++; if (bus.io_rden !== 1'b0) $display("FAIL rst_io_rden got %b want 0", bus.io_rden); else passed++;
      total++; if (bus.io_wren !== 1'b0) $display("FAIL rst_io_wren got %b want 0", bus.io_wren); else passed++;
      total++; if (bus.device_cs !== 1'b0) $display("FAIL rst_device_cs got %b want 0", bus.device_cs); else passed++;
      total++; if (bus.lpc_en !== 1'b0) $display("FAIL rst_lpc_en got %b want 0", bus.lpc_en); else passed++;
      lreset_n = 1'b1;
      @(posedge lclk);
      #1;
   endtask

   task automatic test_io_write;
      int nw = 0;
      logic exp_oe;
      logic [3:0] exp_out;
      idx = 0;
      bus.dout = 8'hA5;
      send_hdr(4'b0010, 16'h03F8);
      cyc(1'b1, 4'h1);
      cyc(1'b1, 4'h4);
      repeat (8 + W) cyc(1'b1, 4'hF);
      total++; if (t_cs[5] !== 1'b0) $display("FAIL wr_cs_early got %b want 0", t_cs[5]); else passed++;
      total++; if (t_cs[6] !== 1'b1) $display("FAIL wr_cs_hit got %b want 1", t_cs[6]); else passed++;
      total++; if (t_en[6] !== 1'b1) $display("FAIL wr_lpc_en got %b want 1", t_en[6]); else passed++;
      total++; if (t_addr[6] !== 16'h0000) $display("FAIL wr_addr got %h want 0000", t_addr[6]); else passed++;
      total++; if (t_din[8] !== 8'h41) $display("FAIL wr_din got %h want 41", t_din[8]); else passed++;
      total++; if (t_wren[10 + W] !== 1'b1) $display("FAIL wr_wren_time got %b want 1", t_wren[10 + W]); else passed++;
      for (int c = 0; c <= 15 + W; c++) begin
         if (t_wren[c]) nw++;
         if (t_rden[c]) begin
            total++;
            $display("FAIL wr_no_rden cycle %0d got 1 want 0", c);
         end
      end
      total++; if (nw !== 1) $display("FAIL wr_wren_count got %0d want 1", nw); else passed++;
      for (int c = 0; c <= 14 + W; c++) begin
         exp_oe = (c >= 10 && c <= 11 + W);
         total++; if (t_oe[c] !== exp_oe) $display("FAIL wr_oe cycle %0d got %b want %b", c, t_oe[c], exp_oe); else passed++;
      end
      for (int c = 10; c <= 11 + W; c++) begin
         exp_out = (c < 10 + W) ? 4'b0110 : (c == 10 + W) ? 4'b0000 : 4'b1111;
         total++; if (t_out[c] !== exp_out) $display("FAIL wr_lad cycle %0d got %h want %h", c, t_out[c], exp_out); else passed++;
      end
      total++; if (t_cs[12 + W] !== 1'b1) $display("FAIL wr_cs_held got %b want 1", t_cs[12 + W]); else passed++;
      total++; if (t_cs[13 + W] !== 1'b0) $display("FAIL wr_cs_clear got %b want 0", t_cs[13 + W]); else passed++;
      total++; if (t_en[13 + W] !== 1'b0) $display("FAIL wr_en_clear got %b want 0", t_en[13 + W]); else passed++;
   endtask

   task automatic test_io_read;
      int nr = 0;
      logic exp_oe;
      logic [3:0] exp_out;
      idx = 0;
      bus.dout = 8'hA5;
      rd_val   = 8'h60;
      send_hdr(4'b0000, 16'h03FD);
      repeat (10 + W) cyc(1'b1, 4'hF);
      total++; if (t_addr[6] !== 16'h0005) $display("FAIL rd_addr got %h want 0005", t_addr[6]); else passed++;
      total++; if (t_rden[7] !== 1'b1) $display("FAIL rd_rden_time got %b want 1", t_rden[7]); else passed++;
      for (int c = 0; c <= 15 + W; c++) if (t_rden[c]) nr++;
      total++; if (nr !== 1) $display("FAIL rd_rden_count got %0d want 1", nr); else passed++;
      for (int c = 0; c <= 14 + W; c++) begin
         exp_oe = (c >= 8 && c <= 11 + W);
         total++; if (t_oe[c] !== exp_oe) $display("FAIL rd_oe cycle %0d got %b want %b", c, t_oe[c], exp_oe); else passed++;
      end
      for (int c = 8; c <= 11 + W; c++) begin
         if (c < 8 + W) exp_out = 4'b0110;
         else if (c == 8 + W) exp_out = 4'b0000;
         else if (c == 9 + W) exp_out = 4'h0;
         else if (c == 10 + W) exp_out = 4'h6;
         else exp_out = 4'hF;
         total++; if (t_out[c] !== exp_out) $display("FAIL rd_lad cycle %0d got %h want %h", c, t_out[c], exp_out); else passed++;
      end
   endtask

   task automatic test_miss;
      idx = 0;
      send_hdr(4'b0010, 16'h02F8);
      cyc(1'b1, 4'h1);
      cyc(1'b1, 4'h4);
      repeat (8) cyc(1'b1, 4'hF);
      for (int c = 0; c <= 15; c++) begin
         total++;
         if ({t_oe[c], t_rden[c], t_wren[c], t_cs[c], t_en[c]} !== 5'b0)
            $display("FAIL miss_quiet cycle %0d got oe/rd/wr/cs/en=%b want 00000", c,
                     {t_oe[c], t_rden[c], t_wren[c], t_cs[c], t_en[c]});
         else passed++;
      end
   endtask

   task automatic test_cyctype_ignored;
      int nr = 0;
      idx = 0;
      cyc(1'b0, 4'h0);
      cyc(1'b1, 4'b0100);
      repeat (8) cyc(1'b1, 4'h0);
      repeat (4) cyc(1'b1, 4'hF);
      for (int c = 0; c <= 13; c++) begin
         total++;
         if ({t_oe[c], t_rden[c], t_wren[c], t_cs[c], t_en[c]} !== 5'b0)
            $display("FAIL mem_ignored cycle %0d got oe/rd/wr/cs/en=%b want 00000", c,
                     {t_oe[c], t_rden[c], t_wren[c], t_cs[c], t_en[c]});
         else passed++;
      end
      idx = 0;
      bus.dout = 8'hA5;
      rd_val   = 8'h3C;
      send_hdr(4'b0000, 16'h03F9);
      repeat (10 + W) cyc(1'b1, 4'hF);
      total++; if (t_cs[6] !== 1'b1) $display("FAIL f9_cs got %b want 1", t_cs[6]); else passed++;
      total++; if (t_addr[6] !== 16'h0001) $display("FAIL f9_addr got %h want 0001", t_addr[6]); else passed++;
      total++; if (t_out[9 + W] !== 4'hC) $display("FAIL f9_lad_lo got %h want c", t_out[9 + W]); else passed++;
      total++; if (t_out[10 + W] !== 4'h3) $display("FAIL f9_lad_hi got %h want 3", t_out[10 + W]); else passed++;
      for (int c = 0; c <= 15 + W; c++) if (t_rden[c]) nr++;
      total++; if (nr !== 1) $display("FAIL f9_rden_count got %0d want 1", nr); else passed++;
   endtask

   task automatic test_abort;
      int nr = 0;
      int nw = 0;
      int b;
      idx = 0;
      bus.dout = 8'hA5;
      rd_val   = 8'h5A;
      send_hdr(4'b0000, 16'h03FA);
      repeat (3 + W) cyc(1'b1, 4'hF);
      b = idx;
      send_hdr(4'b0010, 16'h03FF);
      cyc(1'b1, 4'hE);
      cyc(1'b1, 4'h7);
      repeat (8 + W) cyc(1'b1, 4'hF);
      total++; if (b !== 9 + W) $display("FAIL ab_start_cycle got %0d want %0d", b, 9 + W); else passed++;
      total++; if (t_oe[b] !== 1'b1) $display("FAIL ab_oe_before got %b want 1", t_oe[b]); else passed++;
      total++; if (t_out[b] !== 4'hA) $display("FAIL ab_lad_lo got %h want a", t_out[b]); else passed++;
      for (int c = b + 1; c <= b + 9; c++) begin
         total++; if (t_oe[c] !== 1'b0) $display("FAIL ab_oe_released cycle %0d got %b want 0", c, t_oe[c]); else passed++;
      end
      total++; if (t_cs[b + 1] !== 1'b0) $display("FAIL ab_cs_drop got %b want 0", t_cs[b + 1]); else passed++;
      total++; if (t_en[b + 1] !== 1'b0) $display("FAIL ab_en_drop got %b want 0", t_en[b + 1]); else passed++;
      for (int c = 0; c < idx && c < 64; c++) begin
         if (t_rden[c]) nr++;
         if (t_wren[c]) nw++;
      end
      total++; if (nr !== 1) $display("FAIL ab_rden_count got %0d want 1", nr); else passed++;
      total++; if (t_cs[b + 6] !== 1'b1) $display("FAIL ab_new_cs got %b want 1", t_cs[b + 6]); else passed++;
      total++; if (t_addr[b + 6] !== 16'h0007) $display("FAIL ab_new_addr got %h want 0007", t_addr[b + 6]); else passed++;
      total++; if (t_din[b + 8] !== 8'h7E) $display("FAIL ab_new_din got %h want 7e", t_din[b + 8]); else passed++;
      total++; if (t_wren[b + 10 + W] !== 1'b1) $display("FAIL ab_new_wren got %b want 1", t_wren[b + 10 + W]); else passed++;
      total++; if (nw !== 1) $display("FAIL ab_wren_count got %0d want 1", nw); else passed++;
   endtask

   task automatic test_async_reset;
      idx = 0;
      send_hdr(4'b0010, 16'h03FC);
      cyc(1'b1, 4'h3);
      cyc(1'b1, 4'hC);
      total++; if (bus.device_cs !== 1'b1) $display("FAIL ar_cs_pre got %b want 1", bus.device_cs); else passed++;
      total++; if (bus.din !== 8'hC3) $display("FAIL ar_din_pre got %h want c3", bus.din); else passed++;
      #3;
      lreset_n = 1'b0;
      #1;
      total++; if (bus.device_cs !== 1'b0) $display("FAIL ar_cs got %b want 0", bus.device_cs); else passed++;
      total++; if (bus.lpc_en !== 1'b0) $display("FAIL ar_en got %b want 0", bus.lpc_en); else passed++;
      total++; if (bus.addr !== 16'h0) $display("FAIL ar_addr got %h want 0000", bus.addr); else passed++;
      total++; if (bus.din !== 8'h0) $display("FAIL ar_din got %h want 00", bus.din); else passed++;
      total++; if (bus.lad_out !== 4'hF) $display("FAIL ar_lad_out got %h want f", bus.lad_out); else passed++;
      @(negedge lclk);
      lreset_n = 1'b1;
      @(posedge lclk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_io_write();
      test_io_read();
      test_miss();
      test_cyctype_ignored();
      test_abort();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/lpc_io_target.md
# lpc_io_target

LPC bus I/O-cycle target that decodes host transactions on LAD[3:0]/LFRAME# and turns them into single-byte register strobes for a downstream peripheral (the COM/UART register block). It sits between the LPC pins and the peripheral: it captures address and write data, pulses read/write strobes, fetches read data and runs SYNC/TAR toward the host. Only I/O read/write cycles inside a fixed 8-byte window are claimed; everything else is ignored.

## Interface
- BASE_ADDR, 16'h03F8, first I/O address claimed; window is BASE_ADDR..BASE_ADDR+7
- SYNC_WAIT, 2, number of long-wait SYNC nibbles (0110) inserted before ready SYNC (used only with LPC_LWAIT_EN)
- lclk  in  1  LPC clock, 33 MHz
- lreset_n  in  1  reset, asynchronous, active-low
- lframe_n  in  1  LPC frame, active-low
- lad_in  in  4  LAD sampled from pins
- lad_out  out  4  LAD value driven when lad_oe=1
- lad_oe  out  1  LAD output enable
- addr  out  16  offset from BASE_ADDR (0..7 in bits [2:0], upper bits 0)
- din  out  8  write data to peripheral
- dout  in  8  read data from peripheral, valid the cycle after io_rden
- io_rden  out  1  one-cycle read strobe
- io_wren  out  1  one-cycle write strobe
- device_cs  out  1  address hit, held until cycle end
- lpc_en  out  1  high while a claimed cycle is in progress

## Operation
- Reset: lad_out=4'hF, lad_oe=0, addr=0, din=0, io_rden=0, io_wren=0, device_cs=0, lpc_en=0, state IDLE.
- States: IDLE, CYCTYPE, ADDR(4 nibbles), WDATA(2), HTAR(2), SYNC, RDATA(2), PTAR(2).
- START: lframe_n=0 with lad_in=0000. Consecutive low-frame cycles restart START; first cycle with lframe_n=1 is CYCTYPE.
- CYCTYPE lad_in[3:1]: 000 = I/O read, 001 = I/O write; any other value -> IDLE, wait for next START.
- ADDR: four nibbles MSB first into 16-bit shift register. After 4th nibble: hit if addr in window -> device_cs=1, lpc_en=1, addr=address-BASE_ADDR; miss -> IDLE, LAD never driven.
- Write: WDATA low nibble then high nibble into din; HTAR 2 cycles (host-owned, not driven); SYNC drives 0000 with io_wren=1 that cycle; PTAR cycle 1 drives 1111, cycle 2 lad_oe=0; then IDLE.
- Read: HTAR 2 cycles, io_rden=1 during HTAR cycle 2; SYNC drives 0000, dout latched at end of SYNC; RDATA drives low nibble then high; PTAR as above.
- device_cs/lpc_en cleared at entry to IDLE.
- Abort: lframe_n=0 in any non-IDLE state -> lad_oe=0, strobes=0, device_cs=0, lpc_en=0 at next edge, START detection resumes; strobes already issued are not repeated or undone.
- addr and din stable from hit until IDLE.

## Timing
- Cycle 0 = START. CYCTYPE 1, ADDR 2-5, hit/device_cs visible cycle 6.
- Write (no wait): WDATA 6-7, HTAR 8-9, SYNC 10 (io_wren high), PTAR 11-12 (lad_oe high 10-11, low from 12).
- Read (no wait): HTAR 6-7 (io_rden high in 7), SYNC 8, RDATA 9-10, PTAR 11-12 (lad_oe high 8-11).
- All outputs registered; strobes exactly one lclk wide.

## Configuration
- LPC_LWAIT_EN defined: SYNC phase emits SYNC_WAIT cycles of 0110 followed by one 0000; read strobe timing unchanged, dout latched at end of the 0000 cycle; write io_wren asserted in the 0000 cycle. All later phases shift by SYNC_WAIT.
- Undefined: single 0000 SYNC, timing as above; SYNC_WAIT ignored.

## Test plan
- I/O write 0x03F8 data 0x41 -> io_wren single pulse cycle 10, addr=0, din=0x41, SYNC 0000 then 1111, lad_oe low at cycle 12.
- I/O read 0x03FD, dout=0x60 presented after io_rden -> LAD 0000, 0x0, 0x6 in cycles 8-10, addr=5.
- I/O write 0x02F8 (miss) -> no strobes, device_cs=0, lad_oe=0 throughout.
- Memory read cycle type 010 -> ignored; following I/O read to 0x03F9 serviced normally.
- lframe_n pulled low during read RDATA cycle 9 -> lad_oe=0 next edge, new START accepted, no extra io_rden.
- With LPC_LWAIT_EN, SYNC_WAIT=2, read 0x03FB -> LAD 0110,0110,0000 cycles 8-10, data cycles 11-12, dout latched end of cycle 10.
